// File: rtl/abofs_share_arbiter.sv
// Round-robin share of one ChunkHead address generator among N_REQ read pipelines.
// A granted job is forwarded once; its result stream is routed back to the owner only.

module abofs_share_lane (
  input  logic sel,
  input  logic mofs_rdy,
  input  logic req_mofs_ack,
  output logic req_mofs_rdy,
  output logic mofs_ack
);
  assign req_mofs_rdy = sel & mofs_rdy;
  assign mofs_ack     = sel & mofs_rdy & req_mofs_ack;
endmodule

module abofs_share_arbiter #(
  parameter int N_REQ   = 2,
  parameter int WBW     = 16,
  parameter int VDIM    = 2,
  parameter int DIM     = 2,
  parameter int GBW     = 16,
  parameter int ICFG_BW = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N_REQ-1:0]                      i_req_rdy,
  output logic [N_REQ-1:0]                      i_req_ack,
  input  logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]   i_req_bofs,
  input  logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]   i_req_aofs,
  input  logic [N_REQ-1:0][ICFG_BW-1:0]         i_req_beg,
  input  logic [N_REQ-1:0][ICFG_BW-1:0]         i_req_end,
  output logic                                  o_abofs_rdy,
  input  logic                                  o_abofs_ack,
  output logic [VDIM-1:0][WBW-1:0]              o_bofs,
  output logic [VDIM-1:0][WBW-1:0]              o_aofs,
  output logic [ICFG_BW-1:0]                    o_beg,
  output logic [ICFG_BW-1:0]                    o_end,
  input  logic                                  i_mofs_rdy,
  output logic                                  i_mofs_ack,
  input  logic [DIM-1:0][GBW-1:0]               i_mofs,
  input  logic [ICFG_BW-1:0]                    i_id,
  output logic [N_REQ-1:0]                      o_mofs_rdy,
  input  logic [N_REQ-1:0]                      o_mofs_ack,
  output logic [DIM-1:0][GBW-1:0]               o_mofs,
  output logic [ICFG_BW-1:0]                    o_id
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;

  logic [PW-1:0]      gnt, gnt_n, ptr, ptr_n, win;
  logic [ICFG_BW-1:0] remain, remain_n, job_len;
  logic               issued, issued_n, found, take, abofs_fire;
  logic [N_REQ-1:0]   lane_sel, lane_ack;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    if (int'(x) >= N_REQ - 1) return '0;
    return x + PW'(1);
  endfunction

  // first ready requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && i_req_rdy[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    ptr_n       = ptr;
    remain_n    = remain;
    issued_n    = issued;
    i_req_ack   = '0;
    o_abofs_rdy = 1'b0;
    abofs_fire  = 1'b0;
    take        = 1'b0;
    job_len     = i_req_end[win] - i_req_beg[win];
    case (state)
      IDLE: if (found && !i_rst) begin
        i_req_ack[win] = 1'b1;
        // empty jobs are consumed here and never reach ChunkHead
        if (job_len == '0) begin
          ptr_n = wrap_inc(win);
        end else begin
          take     = 1'b1;
          gnt_n    = win;
          remain_n = job_len;
          issued_n = 1'b0;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        o_abofs_rdy = !issued && !i_rst;
        abofs_fire  = o_abofs_rdy && o_abofs_ack;
        if (abofs_fire) issued_n = 1'b1;
        remain_n = remain - ICFG_BW'(i_mofs_ack);
        // job input and final result may complete in the same cycle
        if ((issued || abofs_fire) && remain_n == '0) begin
          state_n = IDLE;
          ptr_n   = wrap_inc(gnt);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    lane_sel = '0;
    for (int r = 0; r < N_REQ; r++)
      lane_sel[r] = (state == BUSY) && !i_rst && (gnt == PW'(r));
  end

  for (genvar r = 0; r < N_REQ; r++) begin : g_lane
    abofs_share_lane u_lane (
      .sel          (lane_sel[r]),
      .mofs_rdy     (i_mofs_rdy),
      .req_mofs_ack (o_mofs_ack[r]),
      .req_mofs_rdy (o_mofs_rdy[r]),
      .mofs_ack     (lane_ack[r])
    );
  end

  assign i_mofs_ack = |lane_ack;
  assign o_mofs     = i_mofs;
  assign o_id       = i_id;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      remain <= '0;
      issued <= 1'b0;
      o_bofs <= '0;
      o_aofs <= '0;
      o_beg  <= '0;
      o_end  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      remain <= remain_n;
      issued <= issued_n;
      if (take) begin
        o_bofs <= i_req_bofs[win];
        o_aofs <= i_req_aofs[win];
        o_beg  <= i_req_beg[win];
        o_end  <= i_req_end[win];
      end
    end
  end
endmodule

// File: tb/tb_abofs_share_arbiter.sv
// Randomized bench for abofs_share_arbiter: cycle-level reference model plus
// per-requester result scoreboards fed at job acceptance and drained by a monitor.

module tb_abofs_share_arbiter;
  localparam int N_REQ = 2, WBW = 16, VDIM = 2, DIM = 2, GBW = 16, ICFG_BW = 4;

  typedef struct packed {
    logic [VDIM-1:0][WBW-1:0] bofs;
    logic [VDIM-1:0][WBW-1:0] aofs;
    logic [ICFG_BW-1:0]       beg;
    logic [ICFG_BW-1:0]       en;
  } job_t;

  typedef struct packed {
    logic [ICFG_BW-1:0]     id;
    logic [DIM-1:0][GBW-1:0] mofs;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                i_rst = 1'b1;
  logic [N_REQ-1:0]                    i_req_rdy = '0, i_req_ack;
  logic [N_REQ-1:0][VDIM-1:0][WBW-1:0] i_req_bofs, i_req_aofs;
  logic [N_REQ-1:0][ICFG_BW-1:0]       i_req_beg, i_req_end;
  logic                                o_abofs_rdy, o_abofs_ack = 1'b0;
  logic [VDIM-1:0][WBW-1:0]            o_bofs, o_aofs;
  logic [ICFG_BW-1:0]                  o_beg, o_end;
  logic                                i_mofs_rdy = 1'b0, i_mofs_ack;
  logic [DIM-1:0][GBW-1:0]             i_mofs = '0;
  logic [ICFG_BW-1:0]                  i_id = '0;
  logic [N_REQ-1:0]                    o_mofs_rdy, o_mofs_ack = '0;
  logic [DIM-1:0][GBW-1:0]             o_mofs;
  logic [ICFG_BW-1:0]                  o_id;

  job_t req_job [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_drv
    assign i_req_bofs[g] = req_job[g].bofs;
    assign i_req_aofs[g] = req_job[g].aofs;
    assign i_req_beg[g]  = req_job[g].beg;
    assign i_req_end[g]  = req_job[g].en;
  end

  abofs_share_arbiter #(.N_REQ(N_REQ), .WBW(WBW), .VDIM(VDIM), .DIM(DIM), .GBW(GBW),
                        .ICFG_BW(ICFG_BW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_rdy(i_req_rdy), .i_req_ack(i_req_ack),
    .i_req_bofs(i_req_bofs), .i_req_aofs(i_req_aofs),
    .i_req_beg(i_req_beg), .i_req_end(i_req_end),
    .o_abofs_rdy(o_abofs_rdy), .o_abofs_ack(o_abofs_ack),
    .o_bofs(o_bofs), .o_aofs(o_aofs), .o_beg(o_beg), .o_end(o_end),
    .i_mofs_rdy(i_mofs_rdy), .i_mofs_ack(i_mofs_ack), .i_mofs(i_mofs), .i_id(i_id),
    .o_mofs_rdy(o_mofs_rdy), .o_mofs_ack(o_mofs_ack), .o_mofs(o_mofs), .o_id(o_id)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ChunkHead address for one config index of a job
  function automatic logic [DIM-1:0][GBW-1:0] addr_of(input job_t j, input logic [ICFG_BW-1:0] id);
    logic [DIM-1:0][GBW-1:0] a;
    for (int d = 0; d < DIM; d++)
      a[d] = GBW'(j.bofs[d % VDIM]) + GBW'(j.aofs[d % VDIM]) * GBW'(3) + GBW'(id) + GBW'(d * 256);
    return a;
  endfunction

  // reference model and scoreboards
  job_t exp_job_q [$];
  res_t exp_res_q [N_REQ][$];
  int   gnt_log [$];
  logic m_busy = 1'b0, m_issued = 1'b0;
  int   m_ptr = 0, m_gnt = 0, m_owed = 0;
  int   deliv [N_REQ];

  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_ack;
    int   w, idx;
    logic fire_res, fire_job;
    job_t j;
    res_t rr;
    if (i_rst) begin
      m_busy = 1'b0; m_issued = 1'b0; m_ptr = 0; m_gnt = 0; m_owed = 0;
      exp_job_q.delete();
      for (int r = 0; r < N_REQ; r++) exp_res_q[r].delete();
    end else begin
      exp_ack = '0;
      w = -1;
      if (!m_busy)
        for (int k = 0; k < N_REQ; k++) begin
          idx = (m_ptr + k) % N_REQ;
          if (w < 0 && i_req_rdy[idx]) w = idx;
        end
      if (w >= 0) exp_ack[w] = 1'b1;
      check("req_ack", i_req_ack, exp_ack);
      if (m_busy) begin
        check("abofs_rdy", o_abofs_rdy, !m_issued);
        fire_job = !m_issued && o_abofs_ack;
        fire_res = i_mofs_rdy && o_mofs_ack[m_gnt];
        check("mofs_rdy_route", o_mofs_rdy, N_REQ'(i_mofs_rdy) << m_gnt);
        check("mofs_ack", i_mofs_ack, fire_res);
        if (fire_job) m_issued = 1'b1;
        if (fire_res) m_owed--;
        if (m_issued && m_owed == 0) begin
          m_busy = 1'b0;
          m_ptr  = (m_gnt + 1) % N_REQ;
        end
      end else begin
        check("idle_quiet", {o_abofs_rdy, i_mofs_ack, o_mofs_rdy}, '0);
        if (w >= 0) begin
          gnt_log.push_back(w);
          j = req_job[w];
          if (j.beg == j.en) m_ptr = (w + 1) % N_REQ;
          else begin
            m_busy = 1'b1; m_gnt = w; m_issued = 1'b0;
            m_owed = int'(j.en) - int'(j.beg);
            exp_job_q.push_back(j);
            for (int id = int'(j.beg); id < int'(j.en); id++) begin
              rr.id   = ICFG_BW'(id);
              rr.mofs = addr_of(j, ICFG_BW'(id));
              exp_res_q[w].push_back(rr);
            end
          end
        end
      end
    end
  end

  // monitor: pops scoreboards on every observed transfer
  always @(negedge clk) begin
    res_t er;
    job_t ej;
    if (!i_rst) begin
      for (int r = 0; r < N_REQ; r++)
        if (o_mofs_rdy[r] && o_mofs_ack[r]) begin
          check("res_expected", exp_res_q[r].size() != 0, 1'b1);
          if (exp_res_q[r].size() != 0) begin
            er = exp_res_q[r].pop_front();
            check("res_data", {o_id, o_mofs}, {er.id, er.mofs});
            deliv[r]++;
          end
        end
      if (o_abofs_rdy && o_abofs_ack) begin
        check("job_expected", exp_job_q.size() != 0, 1'b1);
        if (exp_job_q.size() != 0) begin
          ej = exp_job_q.pop_front();
          check("job_payload", {o_bofs, o_aofs, o_beg, o_end}, {ej.bofs, ej.aofs, ej.beg, ej.en});
        end
      end
    end
  end

  // stimulus: requesters, ChunkHead stub, result sinks
  int   req_done [N_REQ];
  int   sink_pct [N_REQ];
  int   ch_ack_pct = 100, ch_res_pct = 100, auto_pct = 0, auto_len = -1;
  logic ch_active = 1'b0, ch_acked = 1'b0;
  job_t ch_job;
  int   ch_next = 0;

  task automatic new_job(input int r, input int b, input int len);
    job_t j;
    for (int v = 0; v < VDIM; v++) begin
      j.bofs[v] = WBW'($urandom);
      j.aofs[v] = WBW'($urandom);
    end
    j.beg = ICFG_BW'(b);
    j.en  = ICFG_BW'(b + len);
    req_job[r]   = j;
    i_req_rdy[r] = 1'b1;
  endtask

  task automatic cycle();
    logic [N_REQ-1:0] f_req;
    logic f_job, f_res, hold;
    int   b, l;
    @(negedge clk);
    f_req = i_req_rdy & i_req_ack;
    f_job = o_abofs_rdy && o_abofs_ack;
    f_res = i_mofs_rdy && i_mofs_ack;
    @(posedge clk);
    #1;
    for (int r = 0; r < N_REQ; r++)
      if (f_req[r]) begin i_req_rdy[r] = 1'b0; req_done[r]++; end
    if (f_job) ch_acked = 1'b1;
    if (f_res) begin
      ch_next++;
      if (ch_next == int'(ch_job.en)) ch_active = 1'b0;
    end
    if (auto_pct > 0)
      for (int r = 0; r < N_REQ; r++)
        if (!i_req_rdy[r] && $urandom_range(99) < auto_pct) begin
          if (auto_len < 0) begin
            b = $urandom_range(15);
            l = $urandom_range((15 - b) < 4 ? (15 - b) : 4);
          end else begin
            b = 0; l = auto_len;
          end
          new_job(r, b, l);
        end
    if (!ch_active && o_abofs_rdy) begin
      ch_job    = '{bofs: o_bofs, aofs: o_aofs, beg: o_beg, en: o_end};
      ch_next   = int'(o_beg);
      ch_active = 1'b1;
      ch_acked  = 1'b0;
    end
    hold       = i_mofs_rdy && !f_res && ch_active;
    i_mofs_rdy = ch_active && (hold || $urandom_range(99) < ch_res_pct);
    i_id       = ICFG_BW'(ch_next);
    i_mofs     = addr_of(ch_job, ICFG_BW'(ch_next));
    // ChunkHead accepts its input no later than with the last result
    o_abofs_ack = ch_active && !ch_acked &&
                  ($urandom_range(99) < ch_ack_pct || (i_mofs_rdy && ch_next == int'(ch_job.en) - 1));
    #1;
    for (int r = 0; r < N_REQ; r++)
      o_mofs_ack[r] = o_mofs_rdy[r] && ($urandom_range(99) < sink_pct[r]);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    i_req_rdy = '0; o_abofs_ack = 1'b0; i_mofs_rdy = 1'b0; o_mofs_ack = '0;
    i_mofs = '0; i_id = '0; ch_active = 1'b0; ch_acked = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    #1;
    check({tag, "_handshake_zero"}, {i_req_ack, o_abofs_rdy, i_mofs_ack, o_mofs_rdy}, '0);
    check({tag, "_payload_zero"}, {o_bofs, o_aofs, o_beg, o_end}, '0);
  endtask

  task automatic wait_deliv(input int r, input int target, input string tag);
    int k = 0;
    while (k < 100 && deliv[r] < target) begin cycle(); k++; end
    check(tag, deliv[r], target);
  endtask

  task automatic wait_done(input int r, input int target, input string tag);
    int k = 0;
    while (k < 100 && req_done[r] < target) begin cycle(); k++; end
    check(tag, req_done[r], target);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    int pend;
    pend = 1;
    while (k < 300 && pend != 0) begin
      cycle();
      k++;
      pend = (i_req_rdy != '0 || m_busy || exp_job_q.size() != 0) ? 1 : 0;
      for (int r = 0; r < N_REQ; r++) if (exp_res_q[r].size() != 0) pend = 1;
    end
    check({tag, "_drained"}, pend, 0);
  endtask

  task automatic first_grant(input int g, input int exp, input string tag);
    check({tag, "_grant_seen"}, gnt_log.size() > g, 1'b1);
    if (gnt_log.size() > g) check(tag, gnt_log[g], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, d0, d1, g, k;
    for (int r = 0; r < N_REQ; r++) begin
      sink_pct[r] = 100; deliv[r] = 0; req_done[r] = 0; req_job[r] = '0;
    end
    do_reset("reset");

    // single 3-result job on req0, then ptr must favour req1
    b0 = deliv[0]; b1 = deliv[1];
    new_job(0, 0, 3);
    wait_deliv(0, b0 + 3, "t1_req0_results");
    run(2);
    check("t1_req1_untouched", deliv[1], b1);
    g = gnt_log.size();
    new_job(0, 0, 1); new_job(1, 0, 1);
    run(2);
    first_grant(g, 1, "t1_ptr_after");
    drain("t1");

    // both requesters always ready, 2 results each: grants alternate
    g = gnt_log.size();
    auto_len = 2; auto_pct = 100;
    run(30);
    auto_pct = 0;
    drain("t2");
    check("t2_grant_count", gnt_log.size() - g >= 4, 1'b1);
    for (int i = g + 1; i < gnt_log.size(); i++)
      check("t2_alternate", gnt_log[i] != gnt_log[i-1], 1'b1);

    // empty job on req1: acked, never forwarded, ptr wraps to 0
    d1 = req_done[1];
    new_job(1, 2, 0);
    wait_done(1, d1 + 1, "t3_empty_acked");
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t3_no_forward", o_abofs_rdy, 1'b0);
    end
    g = gnt_log.size();
    new_job(0, 0, 1); new_job(1, 0, 1);
    run(2);
    first_grant(g, 0, "t3_ptr_wrapped");
    drain("t3");

    // requester 1 stalls its result sink: grant held, req0 waits
    sink_pct[1] = 0;
    b1 = deliv[1];
    new_job(1, 0, 3);
    k = 0;
    while (k < 20 && !o_mofs_rdy[1]) begin cycle(); k++; end
    check("t4_result_offered", o_mofs_rdy[1], 1'b1);
    new_job(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_no_mofs_ack", i_mofs_ack, 1'b0);
      check("t4_req0_not_acked", i_req_ack[0], 1'b0);
      check("t4_grant_held", o_mofs_rdy[1], 1'b1);
    end
    check("t4_nothing_delivered", deliv[1], b1);
    sink_pct[1] = 100;
    wait_deliv(1, b1 + 3, "t4_results");
    drain("t4");

    // ChunkHead input ack coincident with the single last result
    ch_ack_pct = 0;
    g = gnt_log.size();
    d0 = req_done[0]; d1 = req_done[1];
    new_job(0, 1, 1);
    wait_done(0, d0 + 1, "t5_req0_acked");
    new_job(1, 0, 1);
    wait_done(1, d1 + 1, "t5_req1_acked");
    check("t5_order", gnt_log.size() >= g + 2, 1'b1);
    if (gnt_log.size() >= g + 2) check("t5_second_grant", gnt_log[g+1], 1);
    ch_ack_pct = 100;
    drain("t5");

    // reset while busy with two results still owed
    b1 = deliv[1];
    new_job(1, 0, 4);
    wait_deliv(1, b1 + 2, "t6_partial");
    do_reset("t6");
    g = gnt_log.size();
    new_job(0, 0, 1); new_job(1, 0, 1);
    run(2);
    first_grant(g, 0, "t6_after_reset");
    drain("t6");

    // randomized traffic
    ch_ack_pct = 50; ch_res_pct = 60; auto_len = -1; auto_pct = 40;
    for (int r = 0; r < N_REQ; r++) sink_pct[r] = 70;
    run(3000);
    auto_pct = 0;
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
